// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer (package pipes).
// Optional performance counters are enabled with PIPELINE_CTRL_PERF_EN.
package pipes;

  typedef logic [63:0] u64;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } ctrl_state_t;

  // Bit order matches the order the pipeline registers are wired: PC first, MEM/WB last.
  typedef struct packed {
    logic stall_pc;
    logic stall_fd;
    logic stall_de;
    logic stall_em;
    logic stall_mw;
    logic flush_fd;
    logic flush_de;
    logic flush_em;
    logic flush_mw;
  } pipe_ctrl_t;

  localparam u64 TARGET_RESET = 64'd0;

  function automatic logic any_flush(input pipe_ctrl_t c);
    return c.flush_fd | c.flush_de | c.flush_em | c.flush_mw;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush/redirect outputs of pipeline_ctrl.
// The master side is the datapath; the slave side is the sequencer.
interface pipeline_ctrl_if;
  import pipes::*;

  logic i_wait;
  logic d_wait;
  logic ex_busy;
  logic load_use;
  logic redirect;
  u64   redirect_pc;

  logic stall_pc;
  logic stall_fd;
  logic stall_de;
  logic stall_em;
  logic stall_mw;
  logic flush_fd;
  logic flush_de;
  logic flush_em;
  logic flush_mw;
  logic pc_redirect;
  u64   pc_target;
  u64   stall_cycles;
  u64   flush_cycles;

  modport master (
    output i_wait, d_wait, ex_busy, load_use, redirect, redirect_pc,
    input  stall_pc, stall_fd, stall_de, stall_em, stall_mw,
    input  flush_fd, flush_de, flush_em, flush_mw,
    input  pc_redirect, pc_target, stall_cycles, flush_cycles
  );

  modport slave (
    input  i_wait, d_wait, ex_busy, load_use, redirect, redirect_pc,
    output stall_pc, stall_fd, stall_de, stall_em, stall_mw,
    output flush_fd, flush_de, flush_em, flush_mw,
    output pc_redirect, pc_target, stall_cycles, flush_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running 64-bit event counter used for the stall/flush statistics.
module pipe_perf_counter
  import pipes::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output u64   count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; holds a redirect while a fetch is in flight.
// Define PIPELINE_CTRL_PERF_EN to build the stall/flush cycle counters.
module pipeline_ctrl
  import pipes::*;
(
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  ctrl_state_t state;
  u64          latched_target;
  pipe_ctrl_t  ctrl;
  logic        pc_redirect;
  u64          pc_target;
  logic        accept;

  // A redirect is only taken when nothing downstream is holding the pipe.
  assign accept = bus.redirect && !bus.d_wait && !bus.ex_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      latched_target <= TARGET_RESET;
    end else begin
      case (state)
        RUN: begin
          if (accept && bus.i_wait) begin
            state          <= REDIR_WAIT;
            latched_target <= bus.redirect_pc;
          end
        end
        REDIR_WAIT: begin
          if (accept) begin
            latched_target <= bus.redirect_pc;
          end else if (!bus.i_wait) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Only the highest-priority hazard shapes the control word; REDIR_WAIT adds its own terms on top.
  always_comb begin
    ctrl        = '0;
    pc_redirect = 1'b0;
    pc_target   = (state == REDIR_WAIT) ? latched_target : bus.redirect_pc;
    if (reset) begin
      ctrl.flush_fd = 1'b1;
      ctrl.flush_de = 1'b1;
      ctrl.flush_em = 1'b1;
      ctrl.flush_mw = 1'b1;
      pc_target     = TARGET_RESET;
    end else begin
      if (bus.d_wait) begin
        ctrl.stall_pc = 1'b1;
        ctrl.stall_fd = 1'b1;
        ctrl.stall_de = 1'b1;
        ctrl.stall_em = 1'b1;
        ctrl.flush_mw = 1'b1;
      end else if (bus.ex_busy) begin
        ctrl.stall_pc = 1'b1;
        ctrl.stall_fd = 1'b1;
        ctrl.stall_de = 1'b1;
        ctrl.flush_em = 1'b1;
      end else if (accept) begin
        ctrl.flush_fd = 1'b1;
        ctrl.flush_de = 1'b1;
        if (state == RUN && !bus.i_wait) begin
          pc_redirect = 1'b1;
        end
      end else if (bus.load_use) begin
        ctrl.stall_pc = 1'b1;
        ctrl.stall_fd = 1'b1;
        ctrl.flush_de = 1'b1;
      end else if (bus.i_wait) begin
        ctrl.stall_pc = 1'b1;
        ctrl.flush_fd = 1'b1;
      end

      // The held target loads as soon as the fetch returns, even under a downstream stall.
      if (state == REDIR_WAIT) begin
        ctrl.flush_fd = 1'b1;
        if (bus.i_wait) begin
          ctrl.stall_pc = 1'b1;
        end else if (!accept) begin
          pc_redirect = 1'b1;
        end
      end
    end
  end

  assign bus.stall_pc    = ctrl.stall_pc;
  assign bus.stall_fd    = ctrl.stall_fd;
  assign bus.stall_de    = ctrl.stall_de;
  assign bus.stall_em    = ctrl.stall_em;
  assign bus.stall_mw    = ctrl.stall_mw;
  assign bus.flush_fd    = ctrl.flush_fd;
  assign bus.flush_de    = ctrl.flush_de;
  assign bus.flush_em    = ctrl.flush_em;
  assign bus.flush_mw    = ctrl.flush_mw;
  assign bus.pc_redirect = pc_redirect;
  assign bus.pc_target   = pc_target;

`ifdef PIPELINE_CTRL_PERF_EN
  logic flush_any;
  assign flush_any = any_flush(ctrl);

  pipe_perf_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl.stall_pc),
    .count (bus.stall_cycles)
  );

  pipe_perf_counter u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_any),
    .count (bus.flush_cycles)
  );
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each row pushes its expected control word, popped at the negedge.
module tb_pipeline_ctrl;
  import pipes::*;

  typedef struct {
    string      name;
    logic       rst;
    logic       iw;
    logic       dw;
    logic       eb;
    logic       lu;
    logic       rd;
    logic [63:0] rpc;
    logic [8:0] ctrl;
    logic       pr;
    logic [63:0] tgt;
  } row_t;

  typedef struct {
    string       name;
    logic [73:0] v;
  } exp_t;

  logic clk;
  logic reset;
  pipeline_ctrl_if bus();

  pipeline_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_stall = '0;
  logic [63:0] exp_flush = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want summary");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic row_t mk(input string name, input logic rst, input logic iw, input logic dw,
                              input logic eb, input logic lu, input logic rd, input logic [63:0] rpc,
                              input logic [8:0] ctrl, input logic pr, input logic [63:0] tgt);
    row_t r;
    r.name = name; r.rst = rst; r.iw = iw; r.dw = dw; r.eb = eb; r.lu = lu; r.rd = rd;
    r.rpc = rpc; r.ctrl = ctrl; r.pr = pr; r.tgt = tgt;
    return r;
  endfunction

  function automatic logic [73:0] obs();
    return {bus.stall_pc, bus.stall_fd, bus.stall_de, bus.stall_em, bus.stall_mw,
            bus.flush_fd, bus.flush_de, bus.flush_em, bus.flush_mw, bus.pc_redirect, bus.pc_target};
  endfunction

  task automatic run_row(input row_t r);
    exp_t e;
    reset           = r.rst;
    bus.i_wait      = r.iw;
    bus.d_wait      = r.dw;
    bus.ex_busy     = r.eb;
    bus.load_use    = r.lu;
    bus.redirect    = r.rd;
    bus.redirect_pc = r.rpc;
    e.name = r.name;
    e.v    = {r.ctrl, r.pr, r.tgt};
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Counter model follows the bench's own expected control word for each completed clock edge.
  task automatic advance(input row_t r);
    @(posedge clk);
    #1;
`ifdef PIPELINE_CTRL_PERF_EN
    if (r.rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (r.ctrl[8]) exp_stall = exp_stall + 64'd1;
      if (|r.ctrl[3:0]) exp_flush = exp_flush + 64'd1;
    end
`endif
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("reset_redirect", 1, 1, 0, 0, 0, 1, 64'h8000_0100, 9'h00F, 0, 64'h0));
    rows.push_back(mk("reset_dwait",    1, 0, 1, 1, 1, 0, 64'h0000_1234, 9'h00F, 0, 64'h0));
    foreach (rows[i]) begin
      run_row(rows[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, obs(), e.v);
      end
      total++;
      if ({bus.stall_cycles, bus.flush_cycles} !== {exp_stall, exp_flush}) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name, bus.stall_cycles, bus.flush_cycles, exp_stall, exp_flush);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("idle",     0, 0, 0, 0, 0, 0, 64'h0000_1234, 9'h000, 0, 64'h0000_1234));
    rows.push_back(mk("load_use", 0, 0, 0, 0, 1, 0, 64'h0000_1234, 9'h184, 0, 64'h0000_1234));
    rows.push_back(mk("i_wait",   0, 1, 0, 0, 0, 0, 64'h0000_5678, 9'h108, 0, 64'h0000_5678));
    foreach (rows[i]) begin
      run_row(rows[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, obs(), e.v);
      end
      total++;
      if ({bus.stall_cycles, bus.flush_cycles} !== {exp_stall, exp_flush}) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name, bus.stall_cycles, bus.flush_cycles, exp_stall, exp_flush);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_d_wait();
    row_t rows[$];
    exp_t e;
    for (int k = 0; k < 3; k++)
      rows.push_back(mk("d_wait_load_use", 0, 0, 1, 0, 1, 0, 64'h0000_0040, 9'h1E1, 0, 64'h0000_0040));
    rows.push_back(mk("d_wait_redirect", 0, 0, 1, 1, 0, 1, 64'h0000_0700, 9'h1E1, 0, 64'h0000_0700));
    foreach (rows[i]) begin
      run_row(rows[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, obs(), e.v);
      end
      total++;
      if ({bus.stall_cycles, bus.flush_cycles} !== {exp_stall, exp_flush}) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name, bus.stall_cycles, bus.flush_cycles, exp_stall, exp_flush);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_redirect();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("redirect",          0, 0, 0, 0, 0, 1, 64'h8000_0100, 9'h00C, 1, 64'h8000_0100));
    rows.push_back(mk("redirect_loaduse",  0, 0, 0, 0, 1, 1, 64'h8000_0180, 9'h00C, 1, 64'h8000_0180));
    foreach (rows[i]) begin
      run_row(rows[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, obs(), e.v);
      end
      total++;
      if ({bus.stall_cycles, bus.flush_cycles} !== {exp_stall, exp_flush}) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name, bus.stall_cycles, bus.flush_cycles, exp_stall, exp_flush);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_redirect_wait();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("rw_accept",  0, 1, 0, 0, 0, 1, 64'h8000_0200, 9'h00C, 0, 64'h8000_0200));
    rows.push_back(mk("rw_hold1",   0, 1, 0, 0, 0, 0, 64'h0000_DEAD, 9'h108, 0, 64'h8000_0200));
    rows.push_back(mk("rw_hold2",   0, 1, 0, 0, 0, 0, 64'h0000_DEAD, 9'h108, 0, 64'h8000_0200));
    rows.push_back(mk("rw_release", 0, 0, 0, 0, 0, 0, 64'h0000_DEAD, 9'h008, 1, 64'h8000_0200));
    rows.push_back(mk("rw_run",     0, 0, 0, 0, 0, 0, 64'h0000_DEAD, 9'h000, 0, 64'h0000_DEAD));
    rows.push_back(mk("rwd_accept", 0, 1, 0, 0, 0, 1, 64'h0000_0300, 9'h00C, 0, 64'h0000_0300));
    rows.push_back(mk("rwd_dwait",  0, 0, 1, 0, 0, 0, 64'h0000_BEEF, 9'h1E9, 1, 64'h0000_0300));
    rows.push_back(mk("rwd_run",    0, 0, 0, 0, 0, 0, 64'h0000_BEEF, 9'h000, 0, 64'h0000_BEEF));
    foreach (rows[i]) begin
      run_row(rows[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, obs(), e.v);
      end
      total++;
      if ({bus.stall_cycles, bus.flush_cycles} !== {exp_stall, exp_flush}) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name, bus.stall_cycles, bus.flush_cycles, exp_stall, exp_flush);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_ex_busy();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("exb_hold1",  0, 0, 0, 1, 0, 1, 64'h8000_0400, 9'h1C2, 0, 64'h8000_0400));
    rows.push_back(mk("exb_hold2",  0, 0, 0, 1, 0, 1, 64'h8000_0400, 9'h1C2, 0, 64'h8000_0400));
    rows.push_back(mk("exb_accept", 0, 0, 0, 0, 0, 1, 64'h8000_0400, 9'h00C, 1, 64'h8000_0400));
    foreach (rows[i]) begin
      run_row(rows[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, obs(), e.v);
      end
      total++;
      if ({bus.stall_cycles, bus.flush_cycles} !== {exp_stall, exp_flush}) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name, bus.stall_cycles, bus.flush_cycles, exp_stall, exp_flush);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_reset_in_wait();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("rst_w_accept", 0, 1, 0, 0, 0, 1, 64'h0000_0500, 9'h00C, 0, 64'h0000_0500));
    rows.push_back(mk("rst_w_hold",   0, 1, 0, 0, 0, 0, 64'h0000_0550, 9'h108, 0, 64'h0000_0500));
    rows.push_back(mk("rst_w_reset",  1, 1, 0, 0, 0, 0, 64'h0000_0500, 9'h00F, 0, 64'h0));
    rows.push_back(mk("rst_w_after",  0, 0, 0, 0, 0, 0, 64'h0000_0600, 9'h000, 0, 64'h0000_0600));
    rows.push_back(mk("rst_w_iwait",  0, 1, 0, 0, 0, 0, 64'h0000_0600, 9'h108, 0, 64'h0000_0600));
    foreach (rows[i]) begin
      run_row(rows[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, obs(), e.v);
      end
      total++;
      if ({bus.stall_cycles, bus.flush_cycles} !== {exp_stall, exp_flush}) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name, bus.stall_cycles, bus.flush_cycles, exp_stall, exp_flush);
      end
      advance(rows[i]);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.i_wait      = 1'b0;
    bus.d_wait      = 1'b0;
    bus.ex_busy     = 1'b0;
    bus.load_use    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_d_wait();
    test_redirect();
    test_redirect_wait();
    test_ex_busy();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
